req_capture_prio: RTL and testbench
===================================

// Module: req_capture_prio
// PURPOSE
//  Upstream capture stage for the 4-to-2 priority encoder path. Detects rising edges on 4 request
//  lines and holds them as sticky pending bits. Presents the highest-priority pending index with a
//  valid/ack handshake, then clears that bit. Lets short request pulses survive until consumed.
// PARAMETERS
//  N      4           number of request lines (fixed at 4 for this revision)
//  IDX_W  2           index width, = clog2(N)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  req          in   4      request lines, level or pulse; rising edge = new request
//  ack          in   1      consumer accepts presented idx (only meaningful while valid=1)
//  overrun_clr  in   1      synchronous clear of all overrun bits
//  valid        out  1      idx holds a granted pending request
//  idx          out  2      granted index; bit 3 highest priority, bit 0 lowest
//  pending      out  4      current sticky pending vector
//  overrun      out  4      sticky: edge arrived on a line already pending
//  mask         in   4      only when REQ_MASK_EN is defined; 1 = line not presented
// BEHAVIOUR
//  Reset (rst_n=0, async): req_q=0, pending=0, overrun=0, valid=0, idx=0, FSM=IDLE.
//  - req_q resets to 0, so any req held high at reset release counts as an edge at the 1st clock.
//  Edge detect: edge = req & ~req_q. req_q <= req every clock.
//  pending[i] at each clock edge:
//  - set if edge[i]
//  - else cleared if the ack is accepted on i
//  - else held
//  - Set beats clear: a new edge on i in the ack cycle of i leaves pending[i]=1.
//  overrun[i] <= 1 if edge[i] && pending[i] && !(ack accepted on i).
//  - overrun_clr clears all bits; a new overrun in the same cycle wins.
//  Priority: sel = highest set bit of eligible. eligible = pending (or pending & ~mask with REQ_MASK_EN).
//  FSM (2 states, registered outputs):
//  - IDLE: valid=0. If eligible!=0 -> GRANT, load idx=sel, valid<=1.
//  - GRANT: valid=1, idx frozen (a later higher-priority arrival does not preempt).
//    On ack=1: clear pending[idx], valid<=0, -> IDLE.
//    On ack=0: stay.
//  Latency: req rises before clock edge k -> pending=1 after k -> valid=1 after k+1.
//  Throughput: 1 grant per 2 clocks minimum (mandatory IDLE bubble after each ack).
//  ack while valid=0 is ignored. req held high produces one request only (edge based).
//  Reset mid-GRANT drops the grant and all pending state immediately; no ack is expected afterwards.
//  idx holds its last value when valid=0 (not cleared).
// CONFIGURATION
//  REQ_MASK_EN defined:
//  - adds the mask input; masked lines still capture into pending and overrun but are never granted.
//  - Masking a line while it is in GRANT does not revoke the grant.
//  REQ_MASK_EN undefined: no mask port; eligible = pending.
// STRUCTURE
//  Shared package req_capture_pkg: FSM state encodings ST_IDLE=1'b0, ST_GRANT=1'b1; N/IDX_W constants.
//  Sub-module prio_enc4: combinational 4->2 priority encoder (in[3:0] -> idx[1:0], any).
//  Instantiated once on eligible.
// TESTING
//  1. rst_n=0 with req=4'b1111, release -> next clk pending=4'b1111; following clk valid=1, idx=3.
//  2. 1-cycle pulse req=4'b0010, ack held 0 for 5 clks -> valid=1, idx=1 stable; ack=1 -> pending=0, valid=0 next clk.
//  3. req=4'b0101 simultaneous, ack every cycle valid=1 -> grants idx=2 then idx=0, one IDLE cycle between.
//  4. In GRANT idx=0, pulse req[0] again -> overrun=4'b0001; overrun_clr=1 -> overrun=0.
//  5. In GRANT idx=1, new edge on req[1] in ack cycle -> pending[1] stays 1, regranted idx=1 after bubble.
//  6. REQ_MASK_EN, mask=4'b1000, req=4'b1001 -> idx=0 granted, pending[3]=1 held; mask=0 -> idx=3 granted.

Source files
------------

// File: rtl/req_capture_prio_pkg.sv
// Shared constants, FSM encoding and small helpers for the request capture stage.
// Used by the interface, the priority encoder and the top.
package req_capture_pkg;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot vector selecting line `i`.
    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/req_capture_prio_if.sv
// Request/grant bundle between the request sources, the consumer and req_capture_prio.
// The mask signal exists only when REQ_MASK_EN is defined.
interface req_capture_prio_if;
    import req_capture_pkg::*;

    // Handshake: the stage asserts valid with a stable idx and holds both until the
    // consumer raises ack in a cycle where valid=1; that clock edge is the transfer.
    // ack while valid=0 has no effect.
    logic [N-1:0]     req;
    logic             ack;
    logic             overrun_clr;
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     pending;
    logic [N-1:0]     overrun;
    state_t           dbg_state;
`ifdef REQ_MASK_EN
    logic [N-1:0]     mask;
`endif

    modport master (
        output req,
        output ack,
        output overrun_clr,
`ifdef REQ_MASK_EN
        output mask,
`endif
        input  valid,
        input  idx,
        input  pending,
        input  overrun,
        input  dbg_state
    );

    modport slave (
        input  req,
        input  ack,
        input  overrun_clr,
`ifdef REQ_MASK_EN
        input  mask,
`endif
        output valid,
        output idx,
        output pending,
        output overrun,
        output dbg_state
    );

endinterface

// File: rtl/req_capture_prio_prio_enc4.sv
// Combinational 4->2 priority encoder: bit 3 has the highest priority.
// idx is 0 when no input is set; check `any` first.
module prio_enc4
    import req_capture_pkg::*;
(
    input  logic [N-1:0]     in,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b1;
        if (in[3])      idx = 2'd3;
        else if (in[2]) idx = 2'd2;
        else if (in[1]) idx = 2'd1;
        else if (in[0]) idx = 2'd0;
        else            any = 1'b0;
    end

endmodule

// File: rtl/req_capture_prio.sv
// Captures rising edges on the request lines as sticky pending bits and grants the
// highest-priority one through a valid/ack handshake. Optional line masking: REQ_MASK_EN.
module req_capture_prio
    import req_capture_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    req_capture_prio_if.slave   bus
);

    logic [N-1:0]     req_q;
    logic [N-1:0]     pending_r;
    logic [N-1:0]     overrun_r;
    logic             valid_r;
    logic [IDX_W-1:0] idx_r;
    state_t           state_r;

    logic [N-1:0]     req_edge;
    logic [N-1:0]     ack_vec;
    logic [N-1:0]     eligible;
    logic [N-1:0]     pending_nxt;
    logic [N-1:0]     overrun_nxt;
    logic [IDX_W-1:0] sel;
    logic             sel_any;
    logic             ack_acc;

    assign req_edge = bus.req & ~req_q;
    assign ack_acc  = (state_r == ST_GRANT) && bus.ack;
    assign ack_vec  = ack_acc ? onehot(idx_r) : '0;

`ifdef REQ_MASK_EN
    assign eligible = pending_r & ~bus.mask;
`else
    assign eligible = pending_r;
`endif

    // A fresh edge in the same cycle as the ack of that line keeps it pending.
    always_comb begin
        pending_nxt = req_edge | (pending_r & ~ack_vec);
        overrun_nxt = bus.overrun_clr ? '0 : overrun_r;
        overrun_nxt = overrun_nxt | (req_edge & pending_r & ~ack_vec);
    end

    prio_enc4 u_enc (
        .in  (eligible),
        .idx (sel),
        .any (sel_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_r <= '0;
            overrun_r <= '0;
        end else begin
            req_q     <= bus.req;
            pending_r <= pending_nxt;
            overrun_r <= overrun_nxt;
        end
    end

    // Grant FSM; idx is frozen for the whole grant and kept after it ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            idx_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_any) begin
                        state_r <= ST_GRANT;
                        valid_r <= 1'b1;
                        idx_r   <= sel;
                    end
                end
                ST_GRANT: begin
                    if (bus.ack) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid     = valid_r;
    assign bus.idx       = idx_r;
    assign bus.pending   = pending_r;
    assign bus.overrun   = overrun_r;
    assign bus.dbg_state = state_r;

endmodule

// File: tb/tb_req_capture_prio.sv
// Directed bench for req_capture_prio; define REQ_MASK_EN to include the masking scenario.
module tb_req_capture_prio;
    import req_capture_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    req_capture_prio_if bus ();

    req_capture_prio dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        bus.req = v;
        tick();
        bus.req = 4'b0000;
    endtask

    initial begin
        logic [3:0] pend_exp;
        total           = 0;
        bad             = 0;
        rst_n           = 1'b0;
        bus.req         = 4'b1111;
        bus.ack         = 1'b0;
        bus.overrun_clr = 1'b0;
`ifdef REQ_MASK_EN
        bus.mask        = 4'b0000;
`endif
        #3;
        check("rst_valid",   {7'd0, bus.valid}, 8'h00);
        check("rst_idx",     {6'd0, bus.idx},   8'h00);
        check("rst_pending", {4'd0, bus.pending}, 8'h00);
        check("rst_overrun", {4'd0, bus.overrun}, 8'h00);
        check("rst_state",   {7'd0, bus.dbg_state}, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: req held high across reset release counts as edges at the first clock
        tick();
        check("t1_pending", {4'd0, bus.pending}, 8'h0f);
        check("t1_valid0",  {7'd0, bus.valid}, 8'h00);
        pend_exp = 4'b1111;
        for (int k = 3; k >= 0; k--) begin
            tick();
            check("t1_valid", {7'd0, bus.valid}, 8'h01);
            check("t1_idx",   {6'd0, bus.idx},   8'(k));
            check("t1_state", {7'd0, bus.dbg_state}, 8'h01);
            bus.ack = 1'b1;
            tick();
            pend_exp[k] = 1'b0;
            check("t1_drop",  {7'd0, bus.valid}, 8'h00);
            check("t1_pend",  {4'd0, bus.pending}, {4'd0, pend_exp});
            bus.ack = 1'b0;
        end
        bus.req = 4'b0000;
        tick();
        check("t1_held_no_req", {7'd0, bus.valid}, 8'h00);

        // 2: short pulse survives and waits for a late ack
        pulse(4'b0010);
        check("t2_pending", {4'd0, bus.pending}, 8'h02);
        check("t2_valid0",  {7'd0, bus.valid}, 8'h00);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("t2_valid", {7'd0, bus.valid}, 8'h01);
            check("t2_idx",   {6'd0, bus.idx},   8'h01);
            tick();
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t2_pend_clr", {4'd0, bus.pending}, 8'h00);
        check("t2_valid_clr", {7'd0, bus.valid}, 8'h00);
        check("t2_idx_hold", {6'd0, bus.idx}, 8'h01);

        // 3: simultaneous requests, ack held high, one idle bubble between grants
        bus.ack = 1'b1;
        pulse(4'b0101);
        check("t3_pending", {4'd0, bus.pending}, 8'h05);
        tick();
        check("t3_g1_valid", {7'd0, bus.valid}, 8'h01);
        check("t3_g1_idx",   {6'd0, bus.idx},   8'h02);
        tick();
        check("t3_bubble",   {7'd0, bus.valid}, 8'h00);
        check("t3_pend1",    {4'd0, bus.pending}, 8'h01);
        tick();
        check("t3_g2_valid", {7'd0, bus.valid}, 8'h01);
        check("t3_g2_idx",   {6'd0, bus.idx},   8'h00);
        tick();
        check("t3_done",     {4'd0, bus.pending}, 8'h00);
        bus.ack = 1'b0;

        // 4: re-request of a granted line -> overrun; no preemption by line 3
        pulse(4'b0001);
        tick();
        check("t4_idx", {6'd0, bus.idx}, 8'h00);
        tick();
        pulse(4'b1001);
        check("t4_overrun", {4'd0, bus.overrun}, 8'h01);
        check("t4_pending", {4'd0, bus.pending}, 8'h09);
        check("t4_no_preempt", {6'd0, bus.idx}, 8'h00);
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        check("t4_ovr_clr", {4'd0, bus.overrun}, 8'h00);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        tick();
        check("t4_next_idx", {6'd0, bus.idx}, 8'h03);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t4_empty", {4'd0, bus.pending}, 8'h00);

        // 5: new edge on the granted line during its ack cycle keeps it pending
        pulse(4'b0010);
        tick();
        check("t5_idx", {6'd0, bus.idx}, 8'h01);
        tick();
        bus.req = 4'b0010;
        bus.ack = 1'b1;
        tick();
        bus.req = 4'b0000;
        bus.ack = 1'b0;
        check("t5_pend_kept", {4'd0, bus.pending}, 8'h02);
        check("t5_bubble",    {7'd0, bus.valid}, 8'h00);
        check("t5_no_ovr",    {4'd0, bus.overrun}, 8'h00);
        tick();
        check("t5_regrant",   {7'd0, bus.valid}, 8'h01);
        check("t5_regrant_idx", {6'd0, bus.idx}, 8'h01);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t5_empty", {4'd0, bus.pending}, 8'h00);

`ifdef REQ_MASK_EN
        // 6: masked line captures but is not granted until unmasked
        bus.mask = 4'b1000;
        pulse(4'b1001);
        tick();
        check("t6_idx0", {6'd0, bus.idx}, 8'h00);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t6_pend3", {4'd0, bus.pending}, 8'h08);
        tick();
        check("t6_masked", {7'd0, bus.valid}, 8'h00);
        bus.mask = 4'b0000;
        tick();
        tick();
        check("t6_valid3", {7'd0, bus.valid}, 8'h01);
        check("t6_idx3",   {6'd0, bus.idx},   8'h03);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
`endif

        // Reset mid-grant clears everything without a clock
        pulse(4'b0100);
        tick();
        check("t7_granted", {7'd0, bus.valid}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid",   {7'd0, bus.valid}, 8'h00);
        check("t7_rst_pending", {4'd0, bus.pending}, 8'h00);
        check("t7_rst_state",   {7'd0, bus.dbg_state}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_idle_after", {7'd0, bus.valid}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
